// File: rtl/uart_tx_stream_pkg.sv
// rtl/uart_tx_stream_pkg.sv - shared types and constants for the UART transmitter
// Contents:
//   tx_state_t  serializer state (IDLE, START, DATA, STOP)
//   DATA_BITS   payload bits per frame
//   IDLE_LEVEL  level of the serial line when no frame is being sent
package n5_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_stream_if.sv
// rtl/uart_tx_stream_if.sv - valid/ready byte stream feeding the UART transmitter
// Signals:
//   in_valid  in_data is valid this cycle (producer)
//   in_data   byte to transmit (producer)
//   in_ready  transmitter can accept a byte (consumer)
// Modports: master = byte producer, slave = transmitter.
interface uart_tx_stream_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - single-clock byte FIFO buffering bytes ahead of the serializer
// Ports:
//   HCLK, HRESET  clock and synchronous active-high reset
//   push, push_data  write request and byte (ignored when full)
//   pop           read request (ignored when empty)
//   pop_data      byte at the head of the FIFO
//   level         occupancy, 0..DEPTH
//   full, empty   decoded from the registered level
module uart_tx_fifo
  import n5_uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   push,
  input  logic [DATA_BITS-1:0]   push_data,
  input  logic                   pop,
  output logic [DATA_BITS-1:0]   pop_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge HCLK) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_stream.sv
// rtl/uart_tx_stream.sv - 8N1 UART transmitter with byte FIFO, LSB first at HCLK/CLK_DIV baud
// Ports:
//   HCLK, HRESET  clock and synchronous active-high reset
//   en            1 = start new frames, 0 = finish the current frame then idle
//   stream        valid/ready byte input (slave side)
//   level         FIFO occupancy
//   busy          a frame is in progress
//   tx            registered serial line, idle high
module uart_tx_stream
  import n5_uart_pkg::*;
#(
  parameter int CLK_DIV   = 16,
  parameter int DEPTH     = 16,
  parameter int STOP_BITS = 1
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   en,
  uart_tx_stream_if.slave        stream,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   tx
);

  localparam int             BW        = $clog2(CLK_DIV);
  localparam int             IW        = $clog2(DATA_BITS);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [IW-1:0]  BIT_LAST  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0]  STOP_LAST = IW'(STOP_BITS - 1);

  tx_state_t            state;
  logic [BW-1:0]        baud_cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_reg;

  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 baud_last;
  logic                 frame_end;
  logic                 launch;
  logic                 line_next;

  uart_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .push      (stream.in_valid),
    .push_data (stream.in_data),
    .pop       (launch),
    .pop_data  (fifo_data),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign stream.in_ready = ~fifo_full;

  assign baud_last = (baud_cnt == BAUD_LAST);
  // Last cycle of the last stop bit: the only point besides IDLE where a new frame may begin.
  assign frame_end = (state == STOP) && baud_last && (bit_idx == STOP_LAST);
  // Popping the FIFO and starting a frame are the same event.
  assign launch    = en && !fifo_empty && ((state == IDLE) || frame_end);

  // Line level for the current state; registered below so tx trails state by one cycle.
  always_comb begin
    line_next = IDLE_LEVEL;
    case (state)
      START:   line_next = 1'b0;
      DATA:    line_next = shift_reg[0];
      default: line_next = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx        <= IDLE_LEVEL;
      busy      <= 1'b0;
    end else begin
      tx   <= line_next;
      busy <= (state != IDLE);
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (launch) begin
            shift_reg <= fifo_data;
            state     <= START;
          end
        end
        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt  <= '0;
            shift_reg <= {1'b0, shift_reg[DATA_BITS-1:1]};
            if (bit_idx == BIT_LAST) begin
              bit_idx <= '0;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          // bit_idx counts stop bits here so STOP_BITS*CLK_DIV needs no wider counter.
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              if (launch) begin
                shift_reg <= fifo_data;
                state     <= START;
              end else begin
                state <= IDLE;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// tb/tb_uart_tx_stream.sv - self-checking bench for uart_tx_stream (8N1/16 and 8N2/4 instances)
module tb_uart_tx_stream;

  localparam int DA = 16, SA = 1, DB = 4, SB = 2, DEPTH = 16, MAXC = 20000;

  logic       HCLK = 1'b0;
  logic       HRESET = 1'b1;
  logic       en_a = 1'b0, en_b = 1'b0;
  logic [4:0] level_a, level_b;
  logic       busy_a, busy_b, tx_a, tx_b;

  int n_cmp = 0, n_bad = 0;
  int edge_cnt = 0;

  logic hist_tx [2][MAXC];
  logic hist_busy [MAXC];

  typedef struct {
    int         pos;
    logic [7:0] data;
  } frame_t;
  frame_t frames[$];

  uart_tx_stream_if ifa ();
  uart_tx_stream_if ifb ();

  uart_tx_stream #(.CLK_DIV(DA), .DEPTH(DEPTH), .STOP_BITS(SA)) dut_a (
    .HCLK(HCLK), .HRESET(HRESET), .en(en_a), .stream(ifa),
    .level(level_a), .busy(busy_a), .tx(tx_a)
  );

  uart_tx_stream #(.CLK_DIV(DB), .DEPTH(DEPTH), .STOP_BITS(SB)) dut_b (
    .HCLK(HCLK), .HRESET(HRESET), .en(en_b), .stream(ifb),
    .level(level_b), .busy(busy_b), .tx(tx_b)
  );

  always #5 HCLK = ~HCLK;

  // edge_cnt read at a negedge = number of rising edges so far.
  always @(posedge HCLK) edge_cnt <= edge_cnt + 1;

  always @(negedge HCLK) begin
    if (edge_cnt < MAXC) begin
      hist_tx[0][edge_cnt] = tx_a;
      hist_tx[1][edge_cnt] = tx_b;
      hist_busy[edge_cnt]  = busy_a;
    end
  end

  function automatic int dbit(int ch);
    return (ch != 0) ? DB : DA;
  endfunction

  function automatic int sbits(int ch);
    return (ch != 0) ? SB : SA;
  endfunction

  // Terminal-style receiver over the recorded line: falling edge, then mid-bit samples.
  task automatic scan(input int ch, input int from, input int to);
    int d, i;
    logic [7:0] b;
    d = dbit(ch);
    frames.delete();
    i = from;
    while (i + 9 * d < to) begin
      if (hist_tx[ch][i] === 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = hist_tx[ch][i + d / 2 + d * (k + 1)];
        frames.push_back('{pos: i, data: b});
        i = i + 9 * d + d / 2;
      end else begin
        i++;
      end
    end
  endtask

  // Ideal frame: start low for d, 8 data bits LSB first, stop high for s*d.
  function automatic int wave_diverge(int ch, int s, logic [7:0] b);
    int d;
    logic e;
    d = dbit(ch);
    for (int o = 0; o < (9 + sbits(ch)) * d; o++) begin
      if (o < d) e = 1'b0;
      else if (o < 9 * d) e = b[(o - d) / d];
      else e = 1'b1;
      if (hist_tx[ch][s + o] !== e) return o;
    end
    return -1;
  endfunction

  function automatic int first_low(int ch, int from, int to);
    for (int i = from; i < to; i++) if (hist_tx[ch][i] === 1'b0) return i;
    return -1;
  endfunction

  // Called at a negedge; the byte is offered at the following rising edge.
  task automatic push(input int ch, input logic [7:0] d);
    if (ch == 0) begin ifa.in_valid = 1'b1; ifa.in_data = d; end
    else begin ifb.in_valid = 1'b1; ifb.in_data = d; end
    @(negedge HCLK);
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    repeat (3) @(negedge HCLK);
    n_cmp++; if (tx_a !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    n_cmp++; if (level_a !== 5'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", level_a); end
    n_cmp++; if (ifa.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ifa.in_ready); end
    n_cmp++; if (tx_b !== 1'b1) begin n_bad++; $display("FAIL reset_tx_b: got %b want 1", tx_b); end
    HRESET = 1'b0;
    @(negedge HCLK);
  endtask

  task automatic test_single();
    int n, f, bd;
    en_a = 1'b1;
    n = edge_cnt + 1;
    push(0, 8'h41);
    n_cmp++; if (level_a !== 5'd1) begin n_bad++; $display("FAIL single_level: got %0d want 1", level_a); end
    repeat (200) @(negedge HCLK);
    f = first_low(0, n, edge_cnt - 1);
    n_cmp++; if (f !== n + 2) begin n_bad++; $display("FAIL single_latency: fall at %0d want %0d", f, n + 2); end
    bd = -1;
    for (int i = n + 3; i < edge_cnt - 1; i++) if (bd < 0 && hist_busy[i] === 1'b0) bd = i;
    n_cmp++; if (bd !== n + 2 + 10 * DA) begin n_bad++; $display("FAIL single_busy_drop: at %0d want %0d", bd, n + 2 + 10 * DA); end
    scan(0, n, edge_cnt - 1);
    n_cmp++; if (frames.size() !== 1) begin n_bad++; $display("FAIL single_count: got %0d frames want 1", frames.size()); end
    if (frames.size() > 0) begin
      $display("terminal rx: '%c'", frames[0].data);
      n_cmp++; if (frames[0].data !== 8'h41) begin n_bad++; $display("FAIL single_data: got %02h want 41", frames[0].data); end
      n_cmp++; if (wave_diverge(0, frames[0].pos, 8'h41) !== -1) begin n_bad++; $display("FAIL single_wave: diverges at offset %0d want none", wave_diverge(0, frames[0].pos, 8'h41)); end
    end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] model_q[$];
    logic exp_ready;
    int t0;
    en_a = 1'b0;
    for (int k = 0; k < 17; k++) begin
      exp_ready = (model_q.size() < DEPTH);
      n_cmp++; if (ifa.in_ready !== exp_ready) begin n_bad++; $display("FAIL fill_ready[%0d]: got %b want %b", k, ifa.in_ready, exp_ready); end
      if (exp_ready) model_q.push_back(8'(k));
      push(0, 8'(k));
    end
    n_cmp++; if (level_a !== 5'd16) begin n_bad++; $display("FAIL fill_level: got %0d want 16", level_a); end
    n_cmp++; if (ifa.in_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready_full: got %b want 0", ifa.in_ready); end
    en_a = 1'b1;
    t0 = edge_cnt;
    repeat (17 * 10 * DA + 100) @(negedge HCLK);
    scan(0, t0, edge_cnt - 1);
    n_cmp++; if (frames.size() !== model_q.size()) begin n_bad++; $display("FAIL fill_count: got %0d frames want %0d", frames.size(), model_q.size()); end
    for (int k = 0; k < frames.size() && k < model_q.size(); k++) begin
      n_cmp++; if (frames[k].data !== model_q[k]) begin n_bad++; $display("FAIL fill_data[%0d]: got %02h want %02h", k, frames[k].data, model_q[k]); end
      n_cmp++; if (wave_diverge(0, frames[k].pos, model_q[k]) !== -1) begin n_bad++; $display("FAIL fill_wave[%0d]: diverges at offset %0d want none", k, wave_diverge(0, frames[k].pos, model_q[k])); end
    end
    n_cmp++; if (level_a !== 5'd0) begin n_bad++; $display("FAIL fill_drained: level %0d want 0", level_a); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    int t0, nr;
    exp_q = '{8'h48, 8'h69, 8'h0A};
    nr = $urandom_range(2, 4);
    for (int k = 0; k < nr; k++) exp_q.push_back(8'($urandom));
    en_a = 1'b1;
    t0 = edge_cnt;
    foreach (exp_q[k]) push(0, exp_q[k]);
    repeat (exp_q.size() * 10 * DA + 100) @(negedge HCLK);
    scan(0, t0, edge_cnt - 1);
    n_cmp++; if (frames.size() !== exp_q.size()) begin n_bad++; $display("FAIL b2b_count: got %0d frames want %0d", frames.size(), exp_q.size()); end
    for (int k = 0; k < frames.size() && k < exp_q.size(); k++) begin
      n_cmp++; if (frames[k].data !== exp_q[k]) begin n_bad++; $display("FAIL b2b_data[%0d]: got %02h want %02h", k, frames[k].data, exp_q[k]); end
      n_cmp++; if (wave_diverge(0, frames[k].pos, exp_q[k]) !== -1) begin n_bad++; $display("FAIL b2b_wave[%0d]: diverges at offset %0d want none", k, wave_diverge(0, frames[k].pos, exp_q[k])); end
      if (k > 0) begin
        n_cmp++; if (frames[k].pos - frames[k-1].pos !== 10 * DA) begin n_bad++; $display("FAIL b2b_period[%0d]: got %0d want %0d", k, frames[k].pos - frames[k-1].pos, 10 * DA); end
      end
    end
  endtask

  task automatic test_en_drop();
    logic [7:0] b [3];
    int t0, e, f;
    for (int k = 0; k < 3; k++) b[k] = 8'($urandom);
    en_a = 1'b1;
    t0 = edge_cnt;
    for (int k = 0; k < 3; k++) push(0, b[k]);
    repeat (60) @(negedge HCLK);
    en_a = 1'b0;
    repeat (300) @(negedge HCLK);
    n_cmp++; if (level_a !== 5'd2) begin n_bad++; $display("FAIL endrop_level: got %0d want 2", level_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL endrop_busy: got %b want 0", busy_a); end
    n_cmp++; if (tx_a !== 1'b1) begin n_bad++; $display("FAIL endrop_tx: got %b want 1", tx_a); end
    scan(0, t0, edge_cnt - 1);
    n_cmp++; if (frames.size() !== 1) begin n_bad++; $display("FAIL endrop_count: got %0d frames want 1", frames.size()); end
    if (frames.size() > 0) begin
      n_cmp++; if (wave_diverge(0, frames[0].pos, b[0]) !== -1) begin n_bad++; $display("FAIL endrop_wave: diverges at offset %0d want none", wave_diverge(0, frames[0].pos, b[0])); end
    end
    en_a = 1'b1;
    e = edge_cnt + 1;
    repeat (2 * 10 * DA + 100) @(negedge HCLK);
    f = first_low(0, e, edge_cnt - 1);
    n_cmp++; if (f !== e + 1) begin n_bad++; $display("FAIL endrop_restart: fall at %0d want %0d", f, e + 1); end
    scan(0, e, edge_cnt - 1);
    n_cmp++; if (frames.size() !== 2) begin n_bad++; $display("FAIL endrop_rest_count: got %0d frames want 2", frames.size()); end
    for (int k = 0; k < frames.size() && k < 2; k++) begin
      n_cmp++; if (frames[k].data !== b[k+1]) begin n_bad++; $display("FAIL endrop_rest_data[%0d]: got %02h want %02h", k, frames[k].data, b[k+1]); end
    end
  endtask

  task automatic test_reset_mid();
    int n, f, t;
    en_a = 1'b1;
    n = edge_cnt + 1;
    f = n + 2;
    push(0, 8'h55);
    for (int k = 0; k < 4; k++) push(0, 8'($urandom));
    repeat (f + 69 - edge_cnt) @(negedge HCLK);
    HRESET = 1'b1;
    @(negedge HCLK);
    n_cmp++; if (hist_tx[0][f + 69] !== 1'b0) begin n_bad++; $display("FAIL rstmid_bit3: got %b want 0", hist_tx[0][f + 69]); end
    n_cmp++; if (tx_a !== 1'b1) begin n_bad++; $display("FAIL rstmid_tx: got %b want 1", tx_a); end
    n_cmp++; if (level_a !== 5'd0) begin n_bad++; $display("FAIL rstmid_level: got %0d want 0", level_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy_a); end
    n_cmp++; if (ifa.in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", ifa.in_ready); end
    HRESET = 1'b0;
    t = edge_cnt;
    repeat (400) @(negedge HCLK);
    scan(0, t, edge_cnt - 1);
    n_cmp++; if (frames.size() !== 0) begin n_bad++; $display("FAIL rstmid_no_frames: got %0d frames want 0", frames.size()); end
  endtask

  task automatic test_stop_bits2();
    logic [7:0] b [2];
    int n;
    b[0] = 8'hA5;
    b[1] = 8'h3C;
    en_b = 1'b1;
    n = edge_cnt + 1;
    push(1, b[0]);
    push(1, b[1]);
    repeat (150) @(negedge HCLK);
    scan(1, n - 1, edge_cnt - 1);
    n_cmp++; if (frames.size() !== 2) begin n_bad++; $display("FAIL stop2_count: got %0d frames want 2", frames.size()); end
    if (frames.size() == 2) begin
      n_cmp++; if (frames[0].pos !== n + 2) begin n_bad++; $display("FAIL stop2_latency: fall at %0d want %0d", frames[0].pos, n + 2); end
      n_cmp++; if (frames[1].pos - frames[0].pos !== 11 * DB) begin n_bad++; $display("FAIL stop2_period: got %0d want %0d", frames[1].pos - frames[0].pos, 11 * DB); end
      for (int k = 0; k < 2; k++) begin
        n_cmp++; if (frames[k].data !== b[k]) begin n_bad++; $display("FAIL stop2_data[%0d]: got %02h want %02h", k, frames[k].data, b[k]); end
        n_cmp++; if (wave_diverge(1, frames[k].pos, b[k]) !== -1) begin n_bad++; $display("FAIL stop2_wave[%0d]: diverges at offset %0d want none", k, wave_diverge(1, frames[k].pos, b[k])); end
      end
    end
  endtask

  initial begin
    ifa.in_valid = 1'b0;
    ifa.in_data  = 8'h00;
    ifb.in_valid = 1'b0;
    ifb.in_data  = 8'h00;
    test_reset();
    test_single();
    test_fill_overflow();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    test_stop_bits2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_stream.md
Name: uart_tx_stream

Overview:
Synthesizable UART transmitter: 8N1 serializer with an on-chip byte FIFO.
- Drives the RsRx input of the UART in soc_core, i.e. the opposite direction of the bench's terminal receiver. Used on the FPGA board as a stimulus source and in simulation as the UART RX driver.
- Bytes enter via a valid/ready stream, are buffered, and are shifted out LSB-first at HCLK/CLK_DIV baud.

Parameters:
CLK_DIV, 16, HCLK cycles per serial bit (legal >= 2; 16 gives 160 ns bits at 100 MHz).
DEPTH, 16, FIFO depth in bytes (power of 2, >= 2).
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
HCLK  input  1  system clock.
HRESET  input  1  synchronous, active-high reset.
en  input  1  1 = start new frames; 0 = finish the current frame, then hold idle.
in_valid  input  1  in_data valid.
in_data  input  8  byte to transmit.
in_ready  output  1  FIFO can accept a byte (= not full).
level  output  $clog2(DEPTH)+1  FIFO occupancy.
busy  output  1  frame in progress (state != IDLE).
tx  output  1  serial line, idle high.

Behaviour:
- Reset: tx=1, busy=0, level=0, in_ready=1; FIFO pointers cleared, FSM in IDLE, baud counter 0. A reset mid-frame drops the frame, raises tx the next cycle and discards all buffered bytes.
- Push: occurs on in_valid & in_ready at a rising edge. in_ready is derived from registered level only. When full, pushes are ignored and the data is not stored.
- Pop: occurs only when level != 0, when the FSM loads the shift register.
- Simultaneous push and pop: level is unchanged. A push into an empty FIFO cannot be popped in the same cycle.
- Pointers wrap modulo DEPTH. level ranges 0..DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if en & level != 0, pop, load shift register, go to START. tx=1.
  - START: tx=0 for CLK_DIV cycles.
  - DATA: 8 bits LSB first, each held CLK_DIV cycles. A bit index 0..7 advances when the baud counter reaches CLK_DIV-1.
  - STOP: tx=1 for STOP_BITS*CLK_DIV cycles. In its last cycle, if en & level != 0, pop and go directly to START; otherwise go to IDLE.
- Baud counter: width $clog2(CLK_DIV). Resets to 0 on every state entry and wraps at CLK_DIV-1.
- Latency: byte pushed at edge N into an empty FIFO with en=1 and the FSM idle. level=1 after N, pop at edge N+1, tx falls after edge N+2.
- Back-to-back frames have no idle gap. Frame period is exactly (9+STOP_BITS)*CLK_DIV cycles.
- en=0 mid-frame: the current frame completes normally, then the FSM stays in IDLE. en rising while idle with data buffered starts a frame on the next edge.
- tx is registered (glitch-free).

Decomposition:
- Package n5_uart_pkg:
  - tx_state_t enum (IDLE, START, DATA, STOP);
  - DATA_BITS=8 constant;
  - IDLE_LEVEL=1'b1 constant.
- Sub-module uart_tx_fifo: synchronous single-clock FIFO with push, pop, data out, level, full and empty; parameter DEPTH; same HCLK/HRESET.
- The FSM, baud counter and shifter live in the top.

Test Plan:
- Single byte (CLK_DIV=16, en=1): push 0x41 at edge N. tx falls after N+2 and holds low 16 cycles. Bit sequence is 1,0,0,0,0,0,1,0, then stop high. A terminal-style monitor with bit_time=160 prints 'A'. busy drops 160 cycles after the frame starts.
- Fill and overflow: with en=0, push 17 bytes 0x00..0x10. in_ready goes low after the 16th push; level=16. The 17th byte is dropped. With en=1 the monitor receives 0x00..0x0F only.
- Back-to-back: with en=1, push "Hi\n". The three frames are contiguous, with start edges exactly 160 cycles apart and no idle cycle between them.
- en drop mid-frame: deassert en during DATA of frame 1 with 2 bytes queued. Frame 1 completes intact, tx stays high and level=2. Reasserting en restarts transmission one edge later.
- Reset mid-frame: assert HRESET during bit 3 of 0x55 with 4 bytes queued. The next cycle shows tx=1, level=0, busy=0, in_ready=1. No further frames follow.
- STOP_BITS=2, CLK_DIV=4: push 0xA5, 0x3C. The frame period is 44 cycles, the stop high lasts 8 cycles, and the decoded bytes match.
